// File: rtl/riscv_pkg.sv
// Shared types for the RV64I load/store path: FSM states, funct3 encodings, alignment check.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SD  = 3'b011;

   // True when the access must be rejected: bad alignment for its size or an unused funct3.
   function automatic logic misalign(input logic we, input logic [2:0] funct3,
                                     input logic [2:0] byte_off);
      logic bad;
      bad = 1'b0;
      if (we && funct3[2]) begin
         bad = 1'b1;
      end else if (!we && funct3 == 3'b111) begin
         bad = 1'b1;
      end else begin
         case (funct3[1:0])
            2'b01:   bad = byte_off[0];
            2'b10:   bad = |byte_off[1:0];
            2'b11:   bad = |byte_off;
            default: bad = 1'b0;
         endcase
      end
      return bad;
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane steering for a doubleword memory: byte enables, store shift, load extract/extend.
// Latency: combinational. Backpressure: none, pure datapath.
// Flow: owned entirely by the enclosing FSM.
import riscv_pkg::*;

module riscv_lsu_align #(
   parameter int DATA_WIDTH = 64
) (
   input  logic [2:0]            funct3,
   input  logic [2:0]            byte_off,
   input  logic [DATA_WIDTH-1:0] st_data,
   input  logic [DATA_WIDTH-1:0] ld_word,
   output logic [7:0]            be,
   output logic [DATA_WIDTH-1:0] st_lane,
   output logic [DATA_WIDTH-1:0] ld_data
);

   logic [5:0]            bit_off;
   logic [DATA_WIDTH-1:0] lane;

   assign bit_off = {byte_off, 3'b000};
   assign st_lane = st_data << bit_off;
   assign lane    = ld_word >> bit_off;

   always_comb begin
      be      = 8'h00;
      ld_data = '0;
      case (funct3[1:0])
         2'b00:   be = 8'h01 << byte_off;
         2'b01:   be = 8'h03 << byte_off;
         2'b10:   be = 8'h0F << byte_off;
         default: be = 8'hFF;
      endcase
      case (funct3)
         F3_LB:   ld_data = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
         F3_LH:   ld_data = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
         F3_LW:   ld_data = {{(DATA_WIDTH-32){lane[31]}}, lane[31:0]};
         F3_LD:   ld_data = lane;
         F3_LBU:  ld_data = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
         F3_LHU:  ld_data = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
         F3_LWU:  ld_data = {{(DATA_WIDTH-32){1'b0}}, lane[31:0]};
         default: ld_data = '0;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// RV64I load/store unit; optional watchdog via RISCV_LSU_TIMEOUT_EN.
// Latency: store 2 cycles, load 3 cycles with zero-wait memory, reject 1 cycle.
// Backpressure: one op in flight; req_ready low and stall high until the response cycle.
import riscv_pkg::*;

module riscv_lsu #(
   parameter int DATA_WIDTH      = 64,
   parameter int DMEM_ADDR_WIDTH = 14,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic                       req_we,
   input  logic [2:0]                 req_funct3,
   input  logic [DATA_WIDTH-1:0]      req_addr,
   input  logic [DATA_WIDTH-1:0]      req_wdata,
   output logic                       rsp_valid,
   output logic [DATA_WIDTH-1:0]      rsp_rdata,
   output logic                       rsp_misalign,
   output logic                       rsp_err,
   output logic                       stall,
   output logic                       mem_cs,
   output logic                       mem_we,
   output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [7:0]                 mem_be,
   output logic [DATA_WIDTH-1:0]      mem_wdata,
   input  logic                       mem_gnt,
   input  logic                       mem_rvalid,
   input  logic [DATA_WIDTH-1:0]      mem_rdata
);

   lsu_state_e            state;
   logic                  lat_we;
   logic [2:0]            lat_funct3;
   logic [2:0]            lat_off;
   logic [2:0]            al_funct3;
   logic [2:0]            al_off;
   logic [7:0]            al_be;
   logic [DATA_WIDTH-1:0] al_st;
   logic [DATA_WIDTH-1:0] al_ld;

`ifdef RISCV_LSU_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   logic [TO_W-1:0] to_cnt;
`endif

   // In IDLE the aligner sees the incoming request so lane outputs can be registered at accept.
   assign al_funct3 = (state == IDLE) ? req_funct3    : lat_funct3;
   assign al_off    = (state == IDLE) ? req_addr[2:0] : lat_off;

   riscv_lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .funct3   (al_funct3),
      .byte_off (al_off),
      .st_data  (req_wdata),
      .ld_word  (mem_rdata),
      .be       (al_be),
      .st_lane  (al_st),
      .ld_data  (al_ld)
   );

   assign stall = ((state == IDLE) & req_valid) | (state == REQ) | (state == WAIT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_misalign <= 1'b0;
         rsp_err      <= 1'b0;
         mem_cs       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_be       <= '0;
         mem_wdata    <= '0;
         lat_we       <= 1'b0;
         lat_funct3   <= '0;
         lat_off      <= '0;
`ifdef RISCV_LSU_TIMEOUT_EN
         to_cnt       <= '0;
`endif
      end else begin
         rsp_valid    <= 1'b0;
         rsp_misalign <= 1'b0;
         rsp_err      <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               lat_we     <= req_we;
               lat_funct3 <= req_funct3;
               lat_off    <= req_addr[2:0];
               req_ready  <= 1'b0;
               if (misalign(req_we, req_funct3, req_addr[2:0])) begin
                  state        <= RESP;
                  rsp_valid    <= 1'b1;
                  rsp_misalign <= 1'b1;
                  rsp_rdata    <= '0;
               end else begin
                  state     <= REQ;
                  mem_cs    <= 1'b1;
                  mem_we    <= req_we;
                  mem_addr  <= req_addr[DMEM_ADDR_WIDTH+2:3];
                  mem_be    <= al_be;
                  mem_wdata <= al_st;
`ifdef RISCV_LSU_TIMEOUT_EN
                  to_cnt    <= '0;
`endif
               end
            end
            REQ: begin
               if (mem_gnt) begin
                  mem_cs <= 1'b0;
                  mem_we <= 1'b0;
                  if (lat_we) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     state <= WAIT;
`ifdef RISCV_LSU_TIMEOUT_EN
                     to_cnt <= '0;
`endif
                  end
               end
`ifdef RISCV_LSU_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  mem_cs    <= 1'b0;
                  mem_we    <= 1'b0;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
`endif
            end
            WAIT: begin
               if (mem_rvalid) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= al_ld;
               end
`ifdef RISCV_LSU_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
`endif
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: vector table driven through a scoreboard queue, plus reset/idle/timeout sequences.
module tb_riscv_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [63:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_misalign, rsp_err, stall;
   logic [63:0] rsp_rdata;
   logic        mem_cs, mem_we, mem_gnt, mem_rvalid;
   logic [13:0] mem_addr;
   logic [7:0]  mem_be;
   logic [63:0] mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   riscv_lsu #(.DATA_WIDTH(64), .DMEM_ADDR_WIDTH(14), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign),
      .rsp_err(rsp_err), .stall(stall),
      .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdata;
      int          gd;
      int          rd;
      logic [7:0]  be;
      logic [13:0] maddr;
      logic [63:0] mwdata;
      logic [63:0] rdexp;
      logic        mis;
   } vec_t;

   typedef struct {
      logic [63:0] rdata;
      logic        mis;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = '0;
      req_wdata  = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
   endtask

   task automatic run_op(input vec_t v, input string tag);
      exp_t e;
      int   c;
      bit   done, stall_ok, cs_seen;
      e.rdata = v.mis ? 64'd0 : v.rdexp;
      e.mis   = v.mis;
      e.cyc   = v.mis ? 1 : (v.we ? 2 + v.gd : 3 + v.gd + v.rd);
      sb_q.push_back(e);
      @(negedge clk);
      chk({tag, "_ready"}, req_ready, 1'b1);
      req_valid  = 1'b1;
      req_we     = v.we;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      #1;
      stall_ok = (stall === 1'b1);
      done = 0; c = 0; cs_seen = 0;
      while (!done && c < 50) begin
         @(negedge clk);
         c++;
         idle_inputs();
         if (mem_cs && !cs_seen) begin
            cs_seen = 1;
            if (!v.mis) begin
               chk({tag, "_we"}, mem_we, v.we);
               chk({tag, "_be"}, mem_be, v.be);
               chk({tag, "_addr"}, mem_addr, v.maddr);
               chk({tag, "_wdata"}, mem_wdata, v.mwdata);
            end
         end
         if (rsp_valid) begin
            done = 1;
            if (sb_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL %s_sb: response with empty scoreboard", tag);
            end else begin
               e = sb_q.pop_front();
               chk({tag, "_rdata"}, rsp_rdata, e.rdata);
               chk({tag, "_misalign"}, rsp_misalign, e.mis);
               chk({tag, "_err"}, rsp_err, 1'b0);
               chk({tag, "_latency"}, c, e.cyc);
               chk({tag, "_stall_resp"}, stall, 1'b0);
            end
         end else begin
            if (stall !== 1'b1) stall_ok = 0;
            if (c == 1 + v.gd && mem_cs) mem_gnt = 1'b1;
            if (!v.we && c == 2 + v.gd + v.rd) begin
               mem_rvalid = 1'b1;
               mem_rdata  = v.rdata;
            end
         end
      end
      if (!done) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: no rsp_valid within 50 cycles", tag);
      end
      chk({tag, "_stall"}, stall_ok, 1'b1);
      chk({tag, "_cs_issued"}, cs_seen, !v.mis);
      @(negedge clk);
      chk({tag, "_hold"}, {rsp_valid, rsp_rdata}, {1'b0, e.rdata});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int c;
      //           we    f3      addr                   wdata                  rdata                  gd rd be     maddr     mwdata                 rdexp                  mis
      vecs[0]  = '{1'b1, 3'b011, 64'h40,                64'h1122334455667788, 64'h0,                 0, 0, 8'hFF, 14'd8,    64'h1122334455667788, 64'h0,                 1'b0};
      vecs[1]  = '{1'b0, 3'b000, 64'h43,                64'h0,                64'h0000000080000000, 0, 0, 8'h08, 14'd8,    64'h0,                64'hFFFFFFFFFFFFFF80, 1'b0};
      vecs[2]  = '{1'b0, 3'b100, 64'h43,                64'h0,                64'h0000000080000000, 0, 0, 8'h08, 14'd8,    64'h0,                64'h80,               1'b0};
      vecs[3]  = '{1'b1, 3'b001, 64'h45,                64'h1234,             64'h0,                 0, 0, 8'h00, 14'd0,    64'h0,                64'h0,                 1'b1};
      vecs[4]  = '{1'b0, 3'b111, 64'h40,                64'h0,                64'h0,                 0, 0, 8'h00, 14'd0,    64'h0,                64'h0,                 1'b1};
      vecs[5]  = '{1'b0, 3'b010, 64'h44,                64'h0,                64'h7FFFFFFF00000000, 3, 1, 8'hF0, 14'd8,    64'h0,                64'h7FFFFFFF,         1'b0};
      vecs[6]  = '{1'b1, 3'b000, 64'h13,                64'hFFFFFFFFFFFFFFAB, 64'h0,                 2, 0, 8'h08, 14'd2,    64'hFFFFFFFFAB000000, 64'h0,                 1'b0};
      vecs[7]  = '{1'b1, 3'b010, 64'h0C,                64'hDEADBEEF,         64'h0,                 0, 0, 8'hF0, 14'd1,    64'hDEADBEEF00000000, 64'h0,                 1'b0};
      vecs[8]  = '{1'b0, 3'b001, 64'h46,                64'h0,                64'h8001000000000000, 0, 2, 8'hC0, 14'd8,    64'h0,                64'hFFFFFFFFFFFF8001, 1'b0};
      vecs[9]  = '{1'b0, 3'b101, 64'h3E,                64'h0,                64'hFFFE000000000000, 0, 0, 8'hC0, 14'd7,    64'h0,                64'hFFFE,             1'b0};
      vecs[10] = '{1'b0, 3'b110, 64'h20,                64'h0,                64'h0000000089ABCDEF, 0, 0, 8'h0F, 14'd4,    64'h0,                64'h89ABCDEF,         1'b0};
      vecs[11] = '{1'b0, 3'b011, 64'h18,                64'h0,                64'h0123456789ABCDEF, 1, 2, 8'hFF, 14'd3,    64'h0,                64'h0123456789ABCDEF, 1'b0};
      vecs[12] = '{1'b0, 3'b010, 64'h42,                64'h0,                64'h0,                 0, 0, 8'h00, 14'd0,    64'h0,                64'h0,                 1'b1};
      vecs[13] = '{1'b1, 3'b011, 64'h44,                64'h55,               64'h0,                 0, 0, 8'h00, 14'd0,    64'h0,                64'h0,                 1'b1};
      vecs[14] = '{1'b1, 3'b100, 64'h40,                64'h55,               64'h0,                 0, 0, 8'h00, 14'd0,    64'h0,                64'h0,                 1'b1};
      vecs[15] = '{1'b0, 3'b000, 64'h01,                64'h0,                64'h0000000000007F00, 0, 0, 8'h02, 14'd0,    64'h0,                64'h7F,               1'b0};
      vecs[16] = '{1'b1, 3'b011, 64'hFFFF00000001FFF8,  64'hCAFE,             64'h0,                 0, 0, 8'hFF, 14'h3FFF, 64'hCAFE,             64'h0,                 1'b0};
      vecs[17] = '{1'b0, 3'b010, 64'h04,                64'h0,                64'h8000000000000000, 0, 0, 8'hF0, 14'd0,    64'h0,                64'hFFFFFFFF80000000, 1'b0};

      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {req_ready, rsp_valid, rsp_misalign, rsp_err, mem_cs, mem_we, stall},
          7'b1000000);
      chk("reset_rdata", rsp_rdata, 64'h0);
      req_valid = 1'b1;
      #1 chk("reset_stall_follows_valid", stall, 1'b1);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) run_op(vecs[i], $sformatf("v%0d", i));

      // Stray memory handshakes while idle must be ignored.
      @(negedge clk);
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'hFFFF;
      @(negedge clk);
      idle_inputs();
      chk("idle_stray", {rsp_valid, req_ready, mem_cs}, 3'b010);

      // Reset while a load waits for data: the late rvalid is dropped.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b011; req_addr = 64'h0;
      @(negedge clk);
      idle_inputs();
      chk("rst_wait_cs", mem_cs, 1'b1);
      mem_gnt = 1'b1;
      @(negedge clk);
      idle_inputs();
      chk("rst_wait_in_wait", {stall, mem_cs}, 2'b10);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 64'h1234567812345678;
      ok = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         idle_inputs();
         if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || stall !== 1'b0) ok = 0;
      end
      chk("rst_wait_no_rsp", ok, 1'b1);
      chk("rst_wait_rdata", rsp_rdata, 64'h0);

`ifdef RISCV_LSU_TIMEOUT_EN
      // Never granted: watchdog aborts after four REQ cycles.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011; req_addr = 64'h40;
      req_wdata = 64'h99;
      c = 0;
      do begin
         @(negedge clk);
         idle_inputs();
         c++;
      end while (rsp_valid !== 1'b1 && c < 20);
      chk("to_latency", c, 5);
      chk("to_err", {rsp_valid, rsp_err, rsp_misalign, mem_cs}, 4'b1100);
      chk("to_rdata", rsp_rdata, 64'h0);
`else
      c = 0;
`endif

      chk("sb_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
